// File: rtl/core_if_ifu_pkg.sv
// Shared widths, reset defaults, opcodes and buffer entry type for the IFU slice.
// The optional static branch predictor is enabled by defining CORE_IFU_BPU_EN.
package core_if_ifu_pkg;

    localparam int CORE_PC_WIDTH   = 32;
    localparam int CORE_INST_WIDTH = 32;
    localparam int CORE_IBUF_DEPTH = 2;

    localparam logic [CORE_PC_WIDTH-1:0] CORE_RST_PC = 32'h8000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [CORE_PC_WIDTH-1:0]   pc;
        logic [CORE_INST_WIDTH-1:0] inst;
        logic                       predict;
    } ibuf_entry_t;

endpackage

// File: rtl/core_if_ifu_if.sv
// Fetch request/response bus between the IFU (master) and instruction memory (slave).
interface core_if_ifu_if;
    import core_if_ifu_pkg::*;

    logic                       ifu_req_valid;
    logic                       ifu_req_ready;
    logic [CORE_PC_WIDTH-1:0]   ifu_req_addr;
    logic                       ifu_rsp_valid;
    logic [CORE_INST_WIDTH-1:0] ifu_rsp_data;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data
    );
endinterface

// File: rtl/core_if_ifu_predecode.sv
// Static predecode: JAL and backward conditional branches are predicted taken.
// Only instantiated when CORE_IFU_BPU_EN is defined.
module core_if_predecode
    import core_if_ifu_pkg::*;
(
    input  logic [CORE_PC_WIDTH-1:0]   pc,
    input  logic [CORE_INST_WIDTH-1:0] inst,
    output logic                       taken,
    output logic [CORE_PC_WIDTH-1:0]   target
);
    logic [CORE_PC_WIDTH-1:0] j_imm;
    logic [CORE_PC_WIDTH-1:0] b_imm;

    assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    always_comb begin
        taken  = 1'b0;
        target = pc;
        if (inst[6:0] == OPC_JAL) begin
            taken  = 1'b1;
            target = pc + j_imm;
        end else if (inst[6:0] == OPC_BRANCH && inst[31]) begin
            taken  = 1'b1;
            target = pc + b_imm;
        end
    end
endmodule

// File: rtl/core_if_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch, in-flight PC FIFO, instruction buffer.
// Define CORE_IFU_BPU_EN to add static predecode with fetch redirect on predicted-taken.
module core_if_ifu
    import core_if_ifu_pkg::*;
#(
    parameter logic [CORE_PC_WIDTH-1:0] RST_PC     = CORE_RST_PC,
    parameter int                       IBUF_DEPTH = CORE_IBUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    core_if_ifu_if.master              mem,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [CORE_PC_WIDTH-1:0]   o_pc,
    output logic [CORE_INST_WIDTH-1:0] o_inst,
    output logic                       o_branch_predict,
    input  logic                       i_pipe_flush_req,
    input  logic [CORE_PC_WIDTH-1:0]   i_flush_pc
);
    localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IBUF_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [CORE_PC_WIDTH-1:0] fetch_pc_reg;
    logic                     started_reg;
    logic [CNT_W-1:0]         outstanding_reg, drop_cnt_reg, ibuf_cnt_reg;
    logic [PTR_W-1:0]         ibuf_rd_ptr_reg, ibuf_wr_ptr_reg, fl_rd_ptr_reg, fl_wr_ptr_reg;
    ibuf_entry_t              ibuf_mem [IBUF_DEPTH];
    logic [CORE_PC_WIDTH-1:0] fl_pc    [IBUF_DEPTH];

    logic                     req_fire, rsp_drop, rsp_accept, ibuf_pop;
    logic                     predict, redirect;
    logic [CORE_PC_WIDTH-1:0] rsp_pc, redirect_target;
    logic [CNT_W:0]           credit_used;
    ibuf_entry_t              head;

    // Credits cover both in-flight requests and buffered instructions, so a response always fits.
    assign credit_used       = {1'b0, outstanding_reg} + {1'b0, ibuf_cnt_reg};
    assign mem.ifu_req_valid = started_reg & (credit_used < (CNT_W+1)'(IBUF_DEPTH))
                             & ~i_pipe_flush_req & ~redirect;
    assign mem.ifu_req_addr  = fetch_pc_reg;
    assign req_fire          = mem.ifu_req_valid & mem.ifu_req_ready;

    assign rsp_pc     = fl_pc[fl_rd_ptr_reg];
    assign rsp_drop   = (drop_cnt_reg != '0);
    assign rsp_accept = mem.ifu_rsp_valid & ~rsp_drop & ~i_pipe_flush_req;

`ifdef CORE_IFU_BPU_EN
    logic pd_taken;

    core_if_predecode u_predecode (
        .pc     (rsp_pc),
        .inst   (mem.ifu_rsp_data),
        .taken  (pd_taken),
        .target (redirect_target)
    );

    assign predict  = pd_taken;
    assign redirect = rsp_accept & pd_taken;
`else
    assign predict         = 1'b0;
    assign redirect        = 1'b0;
    assign redirect_target = '0;
`endif

    assign head             = ibuf_mem[ibuf_rd_ptr_reg];
    assign valid_out        = (ibuf_cnt_reg != '0) & ~i_pipe_flush_req;
    assign o_pc             = head.pc;
    assign o_inst           = head.inst;
    assign o_branch_predict = head.predict;
    assign ibuf_pop         = valid_out & ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RST_PC;
            started_reg  <= 1'b0;
        end else begin
            started_reg <= 1'b1;
            if (i_pipe_flush_req)
                fetch_pc_reg <= i_flush_pc;
            else if (redirect)
                fetch_pc_reg <= redirect_target;
            else if (req_fire)
                fetch_pc_reg <= fetch_pc_reg + CORE_PC_WIDTH'(4);
        end
    end

    // After a flush or redirect every response still in flight is stale and must be discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            fl_rd_ptr_reg   <= '0;
            fl_wr_ptr_reg   <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(mem.ifu_rsp_valid);
            if (req_fire)
                fl_wr_ptr_reg <= ptr_inc(fl_wr_ptr_reg);
            if (mem.ifu_rsp_valid)
                fl_rd_ptr_reg <= ptr_inc(fl_rd_ptr_reg);
            if (i_pipe_flush_req)
                drop_cnt_reg <= outstanding_reg - CNT_W'(mem.ifu_rsp_valid);
            else if (redirect)
                drop_cnt_reg <= outstanding_reg - CNT_W'(1);
            else if (mem.ifu_rsp_valid && rsp_drop)
                drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf_cnt_reg    <= '0;
            ibuf_rd_ptr_reg <= '0;
            ibuf_wr_ptr_reg <= '0;
        end else if (i_pipe_flush_req) begin
            ibuf_cnt_reg    <= '0;
            ibuf_rd_ptr_reg <= '0;
            ibuf_wr_ptr_reg <= '0;
        end else begin
            ibuf_cnt_reg <= ibuf_cnt_reg + CNT_W'(rsp_accept) - CNT_W'(ibuf_pop);
            if (ibuf_pop)
                ibuf_rd_ptr_reg <= ptr_inc(ibuf_rd_ptr_reg);
            if (rsp_accept)
                ibuf_wr_ptr_reg <= ptr_inc(ibuf_wr_ptr_reg);
        end
    end

    for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_entry
        ibuf_entry_t              entry_reg;
        logic [CORE_PC_WIDTH-1:0] fl_pc_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
                fl_pc_reg <= '0;
            end else begin
                if (rsp_accept && ibuf_wr_ptr_reg == PTR_W'(gi))
                    entry_reg <= '{pc: rsp_pc, inst: mem.ifu_rsp_data, predict: predict};
                if (req_fire && fl_wr_ptr_reg == PTR_W'(gi))
                    fl_pc_reg <= fetch_pc_reg;
            end
        end

        assign ibuf_mem[gi] = entry_reg;
        assign fl_pc[gi]    = fl_pc_reg;
    end
endmodule
